// File: rtl/dht11_pkg.sv
// Shared DHT11 definitions: responder state encoding, default timing (in us ticks),
// frame field offsets and the checksum helper. Used by the sensor model, host and benches.
package dht11_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStartLow,
    StGo,
    StRespLow,
    StRespHigh,
    StBitLow,
    StBitHigh,
    StEndLow
  } dht11_state_e;

  localparam int unsigned DefClkDiv    = 50;
  localparam int unsigned DefTStartMin = 18000;
  localparam int unsigned DefTGo       = 30;
  localparam int unsigned DefTResp     = 80;
  localparam int unsigned DefTBitLow   = 50;
  localparam int unsigned DefTZero     = 26;
  localparam int unsigned DefTOne      = 70;

  // Phase counter width; must hold the largest timing constant.
  localparam int unsigned CntW = 16;

  localparam int unsigned FrameBits = 40;
  localparam int unsigned HumHOff   = 32;
  localparam int unsigned HumLOff   = 24;
  localparam int unsigned TmpHOff   = 16;
  localparam int unsigned TmpLOff   = 8;
  localparam int unsigned CksumOff  = 0;

  // Byte sum with 8-bit wrap over {hum_h, hum_l, tmp_h, tmp_l}.
  function automatic logic [7:0] dht11_cksum(input logic [31:0] d);
    logic [9:0] sum;
    sum = 10'(d[31:24]) + 10'(d[23:16]) + 10'(d[15:8]) + 10'(d[7:0]);
    return sum[7:0];
  endfunction

endpackage

// File: rtl/dht11_us_tick.sv
// Free-running CLK_DIV divider producing a one-clk enable every microsecond.
module dht11_us_tick #(
  parameter int unsigned CLK_DIV = 50
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [W-1:0] div_q, div_d;

  assign tick = (div_q == W'(CLK_DIV - 1));

  // Wrap the divider on the tick cycle.
  always_comb begin
    div_d = tick ? '0 : div_q + 1'b1;
  end

  // Divider register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_q <= '0;
    else        div_q <= div_d;
  end

endmodule

// File: rtl/dht11_sensor_model.sv
// DHT11 responder: detects the host start pulse, answers with presence, then sends
// {hum_h, hum_l, tmp_h, tmp_l, checksum} MSB first followed by the end pulse.
// Optional build macro DHT11_CKSUM_ERR_EN adds cksum_err_inject (inverts the sent checksum).
module dht11_sensor_model
  import dht11_pkg::*;
#(
  parameter int unsigned CLK_DIV     = DefClkDiv,
  parameter int unsigned T_START_MIN = DefTStartMin,
  parameter int unsigned T_GO        = DefTGo,
  parameter int unsigned T_RESP      = DefTResp,
  parameter int unsigned T_BIT_LOW   = DefTBitLow,
  parameter int unsigned T_ZERO      = DefTZero,
  parameter int unsigned T_ONE       = DefTOne
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_in,
`ifdef DHT11_CKSUM_ERR_EN
  input  logic        cksum_err_inject,
`endif
  inout  wire         dht11,
  output logic        busy,
  output logic        frame_done,
  output logic        abort
);

  dht11_state_e         state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [5:0]           idx_q, idx_d;
  logic [FrameBits-1:0] frame_q, frame_d;
  logic [1:0]           sync_q;
  logic                 armed_q, armed_d;
  logic                 low_seen_q, low_seen_d;
  logic                 frame_done_q, frame_done_d;
  logic                 abort_q, abort_d;

  logic            tick, line_s, released, drive_low, phase_last, collide;
  logic [CntW-1:0] phase_len;
  logic [7:0]      cksum;

  dht11_us_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  assign line_s    = sync_q[1];
  assign released  = state_q inside {StGo, StRespHigh, StBitHigh};
  assign drive_low = state_q inside {StRespLow, StBitLow, StEndLow};
  assign busy      = state_q inside {StGo, StRespLow, StRespHigh, StBitLow, StBitHigh, StEndLow};
  // Open drain: only ever pull low, the external pull-up supplies the high level.
  assign dht11      = drive_low ? 1'b0 : 1'bz;
  assign frame_done = frame_done_q;
  assign abort      = abort_q;

  // Length of the current timed phase and the collision condition.
  always_comb begin
    phase_len = '0;
    unique case (state_q)
      StGo:                 phase_len = CntW'(T_GO);
      StRespLow, StRespHigh: phase_len = CntW'(T_RESP);
      StBitLow, StEndLow:   phase_len = CntW'(T_BIT_LOW);
      StBitHigh:            phase_len = frame_q[idx_q] ? CntW'(T_ONE) : CntW'(T_ZERO);
      default:              phase_len = '0;
    endcase
    phase_last = tick && ((cnt_q + 1'b1) == phase_len);
    // First tick of a released phase is skipped: the synchronizer may still show our own low.
    collide    = tick && released && (cnt_q != '0) && !line_s && low_seen_q;
  end

  // Next-state and pulse outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    frame_d      = frame_q;
    armed_d      = armed_q;
    low_seen_d   = low_seen_q;
    frame_done_d = 1'b0;
    abort_d      = 1'b0;

    cksum = dht11_cksum(data_in);
`ifdef DHT11_CKSUM_ERR_EN
    if (cksum_err_inject) cksum = ~cksum;
`endif

    unique case (state_q)
      StIdle: begin
        if (line_s) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = StStartLow;
          cnt_d   = '0;
        end
      end
      StStartLow: begin
        if (line_s) begin
          cnt_d = '0;
          if (cnt_q == CntW'(T_START_MIN)) begin
            state_d                 = StGo;
            low_seen_d              = 1'b0;
            frame_d[HumHOff +: 8]  = data_in[31:24];
            frame_d[HumLOff +: 8]  = data_in[23:16];
            frame_d[TmpHOff +: 8]  = data_in[15:8];
            frame_d[TmpLOff +: 8]  = data_in[7:0];
            frame_d[CksumOff +: 8] = cksum;
          end else begin
            state_d = StIdle;
          end
        end else if (tick && (cnt_q < CntW'(T_START_MIN))) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (tick) begin
          cnt_d = cnt_q + 1'b1;
          if (released && (cnt_q != '0)) low_seen_d = !line_s;
          if (collide) begin
            state_d    = StIdle;
            abort_d    = 1'b1;
            armed_d    = 1'b0;
            cnt_d      = '0;
            low_seen_d = 1'b0;
          end else if (phase_last) begin
            cnt_d      = '0;
            low_seen_d = 1'b0;
            case (state_q)
              StGo:      state_d = StRespLow;
              StRespLow: state_d = StRespHigh;
              StRespHigh: begin
                state_d = StBitLow;
                idx_d   = 6'(FrameBits - 1);
              end
              StBitLow:  state_d = StBitHigh;
              StBitHigh: begin
                if (idx_q == '0) begin
                  state_d = StEndLow;
                end else begin
                  state_d = StBitLow;
                  idx_d   = idx_q - 1'b1;
                end
              end
              StEndLow: begin
                state_d      = StIdle;
                frame_done_d = 1'b1;
                // Our own low is still in the synchronizer; wait for a high before rearming.
                armed_d      = 1'b0;
              end
              default:   state_d = StIdle;
            endcase
          end
        end
      end
    endcase
  end

  // State, counters and the bus synchronizer (idles high like the pulled-up line).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      idx_q        <= '0;
      frame_q      <= '0;
      sync_q       <= 2'b11;
      armed_q      <= 1'b0;
      low_seen_q   <= 1'b0;
      frame_done_q <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      frame_q      <= frame_d;
      sync_q       <= {sync_q[0], dht11};
      armed_q      <= armed_d;
      low_seen_q   <= low_seen_d;
      frame_done_q <= frame_done_d;
      abort_q      <= abort_d;
    end
  end

endmodule

// File: tb/tb_dht11_sensor_model.sv
// Bench for dht11_sensor_model with scaled-down timing. Plays the host on the pulled-up bus,
// decodes pulse widths into a frame and compares against an arithmetic frame/checksum model.
module tb_dht11_sensor_model;

  localparam int CD    = 4;
  localparam int TSM   = 20;
  localparam int TGO   = 3;
  localparam int TRESP = 8;
  localparam int TBL   = 5;
  localparam int TZ    = 3;
  localparam int TO    = 7;

  localparam int GoLo  = (TGO - 1) * CD + 2;
  localparam int GoHi  = TGO * CD + 5;
  localparam int GoMax = GoHi + 4 * CD;
  localparam int PhMax = 4 * TO * CD;
  localparam int Quiet = (TGO + 2 * TRESP + 4) * CD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data_in = '0;
  logic        host_low = 1'b0;
  logic        busy, frame_done, abort;
  wire         dht11_bus;
`ifdef DHT11_CKSUM_ERR_EN
  logic        cksum_err_inject = 1'b0;
`endif

  pullup (dht11_bus);
  assign dht11_bus = host_low ? 1'b0 : 1'bz;

  dht11_sensor_model #(
    .CLK_DIV    (CD),
    .T_START_MIN(TSM),
    .T_GO       (TGO),
    .T_RESP     (TRESP),
    .T_BIT_LOW  (TBL),
    .T_ZERO     (TZ),
    .T_ONE      (TO)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .data_in         (data_in),
`ifdef DHT11_CKSUM_ERR_EN
    .cksum_err_inject(cksum_err_inject),
`endif
    .dht11           (dht11_bus),
    .busy            (busy),
    .frame_done      (frame_done),
    .abort           (abort)
  );

  always #5 clk = ~clk;

  int unsigned fd_cnt = 0, ab_cnt = 0, bz_cnt = 0;
  always @(posedge clk) begin
    if (frame_done) fd_cnt <= fd_cnt + 1;
    if (abort)      ab_cnt <= ab_cnt + 1;
    if (busy)       bz_cnt <= bz_cnt + 1;
  end

  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Count consecutive negedge samples at level lvl, starting with the current sample.
  task automatic count_level(input logic lvl, input int max, output int n);
    n = 0;
    while (dht11_bus === lvl && n < max) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic idle(input int clks);
    repeat (clks) @(negedge clk);
  endtask

  task automatic host_start(input int ticks);
    @(negedge clk);
    host_low = 1'b1;
    repeat (ticks * CD) @(negedge clk);
    host_low = 1'b0;
    #1;
  endtask

  // Decode the response. stop_bit >= 0 returns early at the start of that bit's low
  // (stop_high=0) or high (stop_high=1) phase.
  task automatic get_frame(input int stop_bit, input bit stop_high, input bit do_swap,
                           input logic [31:0] swap_val, output logic [39:0] bits);
    int n;
    int bad;
    bits = '0;
    bad  = 0;
    count_level(1'b1, GoMax, n);
    check_rng("go_gap", n, GoLo, GoHi);
    if (n < GoLo || n > GoHi) return;
    check("busy_in_frame", busy, 1);
    count_level(1'b0, PhMax, n);
    check("resp_low", n, TRESP * CD);
    if (do_swap) data_in = swap_val;
    count_level(1'b1, PhMax, n);
    check("resp_high", n, TRESP * CD);
    for (int i = 39; i >= 0; i--) begin
      if (i == stop_bit && !stop_high) return;
      count_level(1'b0, PhMax, n);
      if (n != TBL * CD) bad++;
      if (i == stop_bit) return;
      count_level(1'b1, PhMax, n);
      if (n == TZ * CD)      bits[i] = 1'b0;
      else if (n == TO * CD) bits[i] = 1'b1;
      else                   bad++;
    end
    check("bit_timing_errs", bad, 0);
    count_level(1'b0, PhMax, n);
    check("end_low", n, TBL * CD);
  endtask

  // Reference: frame is the four data bytes then their byte sum mod 256.
  function automatic logic [39:0] model_frame(input logic [31:0] d, input bit inv);
    int s;
    logic [7:0] ck;
    s  = int'(d[31:24]) + int'(d[23:16]) + int'(d[15:8]) + int'(d[7:0]);
    ck = 8'(s % 256);
    if (inv) ck = ~ck;
    return {d, ck};
  endfunction

  task automatic full_frame(input string name, input logic [39:0] exp, input bit do_swap,
                            input logic [31:0] swap_val);
    logic [39:0] got;
    int unsigned fd0;
    fd0 = fd_cnt;
    get_frame(-1, 1'b0, do_swap, swap_val, got);
    check(name, got, exp);
    check("busy_after_end", busy, 0);
    check("bus_released_end", dht11_bus, 1);
    idle(3);
    check("frame_done_once", fd_cnt - fd0, 1);
  endtask

  task automatic no_response(input string name);
    int n;
    int unsigned fd0, bz0;
    fd0 = fd_cnt;
    bz0 = bz_cnt;
    count_level(1'b1, Quiet, n);
    check(name, n, Quiet);
    check("no_busy", bz_cnt - bz0, 0);
    check("no_frame_done", fd_cnt - fd0, 0);
  endtask

  typedef struct {
    logic [31:0] data;
    int          low_ticks;
    bit          resp;
    logic [7:0]  ck;
  } vec_t;

  vec_t        vecs[6];
  logic [39:0] got;
  logic [31:0] d;
  int          n;
  int unsigned fd0, ab0;

  initial begin
    vecs[0] = '{32'h3A00_1905, 2 * TSM, 1'b1, 8'h58};
    vecs[1] = '{32'h3A00_1905, TSM / 4, 1'b0, 8'h00};
    vecs[2] = '{32'hFFFF_FFFF, TSM + 3, 1'b1, 8'hFC};
    vecs[3] = '{32'h0000_0000, TSM + 3, 1'b1, 8'h00};
    vecs[4] = '{32'h1234_5678, TSM - 3, 1'b0, 8'h00};
    vecs[5] = '{32'h8001_7FFE, 2 * TSM, 1'b1, 8'hFE};

    #2;
    check("rst_bus", dht11_bus, 1);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_abort", abort, 0);
    idle(4);
    rst_n = 1'b1;
    idle(5 * CD);

    // Table of start lengths and payloads.
    foreach (vecs[k]) begin
      data_in = vecs[k].data;
      idle(5 * CD);
      host_start(vecs[k].low_ticks);
      if (vecs[k].resp) full_frame($sformatf("frame_vec%0d", k), {vecs[k].data, vecs[k].ck},
                                   1'b0, '0);
      else              no_response($sformatf("quiet_vec%0d", k));
    end

    // data_in changes mid-frame must not disturb the frame in flight.
    data_in = 32'h3A00_1905;
    idle(5 * CD);
    host_start(2 * TSM);
    full_frame("frame_swap", 40'h3A00_1905_58, 1'b1, 32'hFFFF_FFFF);

    // Reset asserted during the low preamble of bit 20.
    data_in = 32'h3A00_1905;
    idle(5 * CD);
    host_start(2 * TSM);
    get_frame(20, 1'b0, 1'b0, '0, got);
    check("bit20_low_setup", dht11_bus, 0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_bus", dht11_bus, 1);
    check("rst_mid_busy", busy, 0);
    idle(3);
    rst_n = 1'b1;
    idle(5 * CD);
    host_start(2 * TSM);
    full_frame("frame_after_rst", model_frame(32'h3A00_1905, 1'b0), 1'b0, '0);

    // Host collides during the high phase of bit 5.
    idle(5 * CD);
    host_start(2 * TSM);
    get_frame(5, 1'b1, 1'b0, '0, got);
    fd0 = fd_cnt;
    ab0 = ab_cnt;
    host_low = 1'b1;
    idle(10 * CD);
    host_low = 1'b0;
    #1;
    idle(2);
    check("abort_pulse", ab_cnt - ab0, 1);
    check("abort_busy", busy, 0);
    count_level(1'b1, Quiet, n);
    check("abort_bus_idle", n, Quiet);
    check("abort_no_done", fd_cnt - fd0, 0);

`ifdef DHT11_CKSUM_ERR_EN
    cksum_err_inject = 1'b1;
    idle(5 * CD);
    host_start(2 * TSM);
    full_frame("frame_inject", 40'h3A00_1905_A7, 1'b0, '0);
    cksum_err_inject = 1'b0;
`endif

    // Random payloads and start lengths against the arithmetic model.
    for (int r = 0; r < 6; r++) begin
      d = $urandom;
      data_in = d;
      idle(5 * CD);
      host_start(int'($urandom_range(2 * TSM, TSM + 3)));
      full_frame($sformatf("frame_rand%0d", r), model_frame(d, 1'b0), 1'b0, '0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
